uram_wr_addr_gen: RTL

Write-side address generator for the convolution output path. It accepts one result beat per input column from the compute pipeline and drops the pipeline-fill beats at the start of each row. It issues URAM write addresses and write enables at a stride of 16, and flags row and frame completion. It is the writer counterpart to the URAM/BRAM line-buffer read address generator, and sits between the compute array and the output URAM.

---
 rtl/uram_wr_addr_gen.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uram_wr_addr_gen.sv
// rtl/uram_wr_addr_gen.sv - URAM write address generator for the convolution output path
// Drops pipeline-fill beats, writes valid results at a stride of 16, flags row/frame ends.
module uram_wr_addr_gen #(
    parameter int IMG_W         = 4,
    parameter int IMG_H         = 4,
    parameter int NUMBER_OF_REG = 1,
    parameter int URAM_A_W      = 23
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                start,
    input  logic                in_valid,
    output logic [URAM_A_W-1:0] uram_wr_addr,
    output logic                uram_wr_en,
    output logic                row_done,
    output logic                frame_done,
    output logic                overflow,
    output logic                busy
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int NR = NUMBER_OF_REG;

    localparam logic [1:0] S_RST   = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CW-1:0]       COL_LAST    = CW'(IMG_W - 1);
    localparam logic [RW-1:0]       ROW_LAST    = RW'(IMG_H - 1);
    localparam logic [URAM_A_W-1:0] ADDR_STRIDE = URAM_A_W'(16);

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       col_cnt_q, col_cnt_d;
    logic [RW-1:0]       row_cnt_q, row_cnt_d;
    logic [URAM_A_W-1:0] wr_addr_next_q, wr_addr_next_d;
    logic                overflow_q, overflow_d;

    logic [NR-1:0]               pipe_en_q, pipe_en_d;
    logic [NR-1:0]               pipe_row_q, pipe_row_d;
    logic [NR-1:0]               pipe_frame_q, pipe_frame_d;
    logic [NR-1:0][URAM_A_W-1:0] pipe_addr_q, pipe_addr_d;

    logic start_c;
    logic accept;
    logic col_last;
    logic row_last;
    logic valid_res;

    always_comb begin
        start_c   = ce && start;
        // A start in the same cycle as a beat takes priority; the beat is dropped.
        accept    = ce && in_valid && !start && (state_q == S_WRITE);
        col_last  = (col_cnt_q == COL_LAST);
        row_last  = (row_cnt_q == ROW_LAST);
        valid_res = accept && (32'(col_cnt_q) >= 32'd2) && (32'(row_cnt_q) >= 32'd2);

        state_d        = state_q;
        col_cnt_d      = col_cnt_q;
        row_cnt_d      = row_cnt_q;
        wr_addr_next_d = wr_addr_next_q;
        overflow_d     = overflow_q;

        case (state_q)
            S_RST: begin
                state_d = S_IDLE;
            end
            S_IDLE, S_DONE: begin
                if (start_c) begin
                    state_d        = S_WRITE;
                    col_cnt_d      = '0;
                    row_cnt_d      = '0;
                    wr_addr_next_d = '0;
                end
            end
            S_WRITE: begin
                if (start_c) begin
                    col_cnt_d      = '0;
                    row_cnt_d      = '0;
                    wr_addr_next_d = '0;
                end else if (accept) begin
                    if (col_last) begin
                        col_cnt_d = '0;
                        row_cnt_d = row_last ? '0 : row_cnt_q + 1'b1;
                    end else begin
                        col_cnt_d = col_cnt_q + 1'b1;
                    end
                    if (valid_res) begin
                        wr_addr_next_d = wr_addr_next_q + ADDR_STRIDE;
                    end
                    if (col_last && row_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_RST;
            end
        endcase

        if (start_c) begin
            overflow_d = 1'b0;
        end else if (ce && in_valid && (state_q != S_WRITE)) begin
            overflow_d = 1'b1;
        end
    end

    // Output delay line; it shifts regardless of ce so in-flight writes always drain.
    always_comb begin
        pipe_en_d    = pipe_en_q;
        pipe_row_d   = pipe_row_q;
        pipe_frame_d = pipe_frame_q;
        pipe_addr_d  = pipe_addr_q;

        pipe_en_d[0]    = valid_res;
        pipe_row_d[0]   = valid_res && col_last;
        pipe_frame_d[0] = valid_res && col_last && row_last;
        pipe_addr_d[0]  = valid_res ? wr_addr_next_q : pipe_addr_q[0];

        for (int i = 1; i < NR; i++) begin
            pipe_en_d[i]    = pipe_en_q[i-1];
            pipe_row_d[i]   = pipe_row_q[i-1];
            pipe_frame_d[i] = pipe_frame_q[i-1];
            pipe_addr_d[i]  = pipe_en_q[i-1] ? pipe_addr_q[i-1] : pipe_addr_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_RST;
            col_cnt_q      <= '0;
            row_cnt_q      <= '0;
            wr_addr_next_q <= '0;
            overflow_q     <= 1'b0;
            pipe_en_q      <= '0;
            pipe_row_q     <= '0;
            pipe_frame_q   <= '0;
            pipe_addr_q    <= '0;
        end else begin
            if (ce) begin
                state_q        <= state_d;
                col_cnt_q      <= col_cnt_d;
                row_cnt_q      <= row_cnt_d;
                wr_addr_next_q <= wr_addr_next_d;
                overflow_q     <= overflow_d;
            end
            pipe_en_q    <= pipe_en_d;
            pipe_row_q   <= pipe_row_d;
            pipe_frame_q <= pipe_frame_d;
            pipe_addr_q  <= pipe_addr_d;
        end
    end

    assign uram_wr_en   = pipe_en_q[NR-1];
    assign uram_wr_addr = pipe_addr_q[NR-1];
    assign row_done     = pipe_row_q[NR-1];
    assign frame_done   = pipe_frame_q[NR-1];
    assign overflow     = overflow_q;
    assign busy         = (state_q == S_WRITE);

endmodule
